apb_cmd_master: RTL and testbench

//  APB3 requester that drives the register-slave pins of tt_um_pchri03_top.

---
 rtl/apb_cmd_master.sv | 118 +++++++++++
 tb/tb_apb_cmd_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB3 requester: turns one valid/ready command into an APB setup+access transfer
// and returns the result on a valid/ready response channel, with an ACCESS-phase timeout.
module apb_cmd_master #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // A zero TIMEOUT disables the counter; keep at least one bit so the vector is legal.
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                // First ACCESS cycle counts as 1.
                cnt_d   = CntOne;
                state_d = StAccess;
            end
            StAccess: begin
                if (pready) begin
                    err_d   = pslverr;
                    rdata_d = pwrite_q ? '0 : prdata;
                    state_d = StResp;
                end else if ((TIMEOUT != 0) && (cnt_q == CntMax)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign psel      = (state_q == StSetup) || (state_q == StAccess);
    assign penable   = (state_q == StAccess);
    assign rsp_valid = (state_q == StResp);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: a wait-state/error-injecting APB slave plus a memory-level
// reference model of what every command should return.
module tb_apb_cmd_master;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Slave under test control: pready on the (cur_wait+1)-th ACCESS cycle, junk elsewhere.
    logic [DW-1:0] slave_mem [8];
    int            cur_wait = 0;
    logic          cur_err = 1'b0;
    int            acc_n = 0;

    always @(negedge pclk) begin
        if (psel && penable) begin
            if (acc_n == cur_wait) begin
                pready  <= 1'b1;
                pslverr <= cur_err;
                prdata  <= pwrite ? DW'($urandom) : slave_mem[paddr];
                if (pwrite && !cur_err) slave_mem[paddr] <= pwdata;
            end else begin
                pready  <= 1'b0;
                pslverr <= 1'($urandom_range(0, 1));
                prdata  <= DW'($urandom);
            end
            acc_n <= acc_n + 1;
        end else begin
            pready  <= 1'($urandom_range(0, 1));
            pslverr <= 1'($urandom_range(0, 1));
            prdata  <= DW'($urandom);
            acc_n   <= 0;
        end
    end

    // Bus monitor: counts select/enable cycles and address-phase instability.
    logic          exp_write = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    int            psel_cnt = 0;
    int            pen_cnt = 0;
    int            bad_cnt = 0;

    always @(negedge pclk) begin
        if (psel) begin
            psel_cnt <= psel_cnt + 1;
            if (penable) pen_cnt <= pen_cnt + 1;
            if (pwrite !== exp_write || paddr !== exp_addr || (exp_write && pwdata !== exp_wdata))
                bad_cnt <= bad_cnt + 1;
        end
    end

    logic [DW-1:0] model_mem [8];

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int wt, input logic e, input int rdly);
        logic [DW-1:0] er;
        logic          ee;
        int            exp_pen, ps0, pe0, bad0, n, unstable;
        logic [DW-1:0] r0;
        logic          e0;
        // Reference: timeout if the slave would need more than TO access cycles.
        if (wt >= TO) begin
            ee = 1'b1; er = '0; exp_pen = TO;
        end else begin
            ee = e; er = w ? '0 : model_mem[a]; exp_pen = wt + 1;
            if (w && !e) model_mem[a] = d;
        end
        @(negedge pclk);
        cur_wait = wt; cur_err = e;
        exp_write = w; exp_addr = a; exp_wdata = d;
        ps0 = psel_cnt; pe0 = pen_cnt; bad0 = bad_cnt;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge pclk); #1;
        // Keep a junk command pending while busy; it must not be taken.
        cmd_write = 1'($urandom_range(0, 1)); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
        n = 0;
        @(negedge pclk);
        while (!rsp_valid && n < 60) begin @(negedge pclk); n++; end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("psel_in_resp", {penable, psel}, 32'd0);
        unstable = 0; r0 = rsp_rdata; e0 = rsp_err;
        for (int i = 0; i < rdly; i++) begin
            @(negedge pclk);
            if (rsp_rdata !== r0 || rsp_err !== e0 || rsp_valid !== 1'b1 || cmd_ready !== 1'b0)
                unstable++;
        end
        check("rsp_hold", 32'(unstable), 32'd0);
        check("rsp_err", 32'(rsp_err), 32'(ee));
        check("rsp_rdata", 32'(rsp_rdata), 32'(er));
        check("psel_cycles", 32'(psel_cnt - ps0), 32'(exp_pen + 1));
        check("penable_cycles", 32'(pen_cnt - pe0), 32'(exp_pen));
        check("addr_stable", 32'(bad_cnt - bad0), 32'd0);
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge pclk);
        check("idle_after_rsp", {rsp_valid, cmd_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            slave_mem[i] = '0;
            model_mem[i] = '0;
        end
        #3;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_outs", {rsp_valid, rsp_err, psel, penable, pwrite, paddr, pwdata, rsp_rdata},
              32'd0);
        @(negedge pclk); @(negedge pclk);
        presetn = 1'b1;

        // Zero-wait writes then reads back.
        xfer(1'b1, 3'd0, 8'hDE, 0, 1'b0, 0);
        xfer(1'b1, 3'd1, 8'hAD, 0, 1'b0, 0);
        xfer(1'b1, 3'd2, 8'hBE, 0, 1'b0, 0);
        xfer(1'b1, 3'd3, 8'hEF, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) xfer(1'b0, AW'(i), 8'h00, 0, 1'b0, 0);
        // Wait states with slave error, timeout, pready on the timeout edge.
        xfer(1'b0, 3'd2, 8'h00, 3, 1'b1, 0);
        xfer(1'b0, 3'd1, 8'h00, 20, 1'b0, 0);
        xfer(1'b1, 3'd6, 8'h5A, 15, 1'b0, 0);
        xfer(1'b0, 3'd6, 8'h00, 15, 1'b0, 0);
        xfer(1'b1, 3'd7, 8'h11, 16, 1'b0, 0);
        xfer(1'b0, 3'd7, 8'h00, 0, 1'b0, 0);
        // Back-pressured response.
        xfer(1'b0, 3'd3, 8'h00, 0, 1'b0, 5);

        // Reset asserted mid-ACCESS: write must be dropped, bus released at once.
        @(negedge pclk);
        cur_wait = 10; cur_err = 1'b0;
        exp_write = 1'b1; exp_addr = 3'd0; exp_wdata = 8'h77;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd0; cmd_wdata = 8'h77;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        check("mid_access", {psel, penable}, 32'd3);
        #2;
        presetn = 1'b0;
        #1;
        check("async_rst_bus", {psel, penable, rsp_valid}, 32'd0);
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        presetn = 1'b1;
        xfer(1'b0, 3'd0, 8'h00, 0, 1'b0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            int wt;
            wt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 19))
                                             : int'($urandom_range(0, 3));
            xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), wt,
                 ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
